// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// pending-write scoreboard used by issue for RAW/WAW hazard stalls.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            claim_valid,
    input  logic [AW-1:0]   claim_addr,
    output logic            claim_stall,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_cnt
);
    localparam int unsigned NREG = 2 ** AW;

    logic            last_grant;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic [AW:0]     cnt_next;

    // Grants depend only on the valids and last_grant, never on addr/data.
    always_comb begin
        req0_ready = req0_valid & (~req1_valid | last_grant);
        req1_ready = req1_valid & (~req0_valid | ~last_grant);
        xfer       = req0_ready | req1_ready;
        win_addr   = req1_ready ? req1_addr : req0_addr;
        win_data   = req1_ready ? req1_data : req0_data;
    end

    always_comb begin
        claim_stall = claim_valid & sb[claim_addr] & (claim_addr != '0);
        rs1_busy    = sb[rs1_addr] & (rs1_addr != '0);
        rs2_busy    = sb[rs2_addr] & (rs2_addr != '0);
    end

    // Clear from the committing write is applied first so a same-edge claim wins.
    always_comb begin
        sb_next = sb;
        if (rf_we) begin
            sb_next[rf_waddr] = 1'b0;
        end
        if (claim_valid && !claim_stall && (claim_addr != '0)) begin
            sb_next[claim_addr] = 1'b1;
        end
        sb_next[0] = 1'b0;
        cnt_next = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + (AW + 1)'(sb_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            sb          <= '0;
            pending_cnt <= '0;
            last_grant  <= 1'b1;
        end else begin
            sb          <= sb_next;
            pending_cnt <= cnt_next;
            if (xfer) begin
                rf_we      <= (win_addr != '0);
                rf_waddr   <= win_addr;
                rf_wdata   <= win_data;
                last_grant <= req1_ready;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: arbitration vector table, hand-written
// hazard/reset sequences and a randomized run against a pending-set model.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic        claim_stall;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic [5:0]  pending_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: set of pending registers plus the registered write port.
    bit          m_pend[32];
    bit          m_last;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    typedef struct {
        bit         v0;
        bit         v1;
        logic [4:0] a0;
        logic [4:0] a1;
        bit         r0;
        bit         r1;
    } vec_t;
    vec_t tbl[10];

    rf_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_stall(claim_stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        claim_valid = 1'b0; claim_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = 1'b1; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    // Assumes we are at a negedge; leaves us at the following negedge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs set by caller at negedge; checks every output, then advances one cycle.
    task automatic mcycle();
        bit g0, g1, stall;
        int cnt;
        #1;
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        stall = claim_valid && (claim_addr != 0) && m_pend[claim_addr];
        cnt = 0;
        foreach (m_pend[i]) cnt += int'(m_pend[i]);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("claim_stall", claim_stall, stall);
        chk("rs1_busy", rs1_busy, (rs1_addr != 0) && m_pend[rs1_addr]);
        chk("rs2_busy", rs2_busy, (rs2_addr != 0) && m_pend[rs2_addr]);
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("pending_cnt", pending_cnt, cnt);
        @(posedge clk);
        if (m_we) m_pend[m_waddr] = 1'b0;
        if (claim_valid && !stall && claim_addr != 0) m_pend[claim_addr] = 1'b1;
        if (g0 || g1) begin
            m_waddr = g1 ? req1_addr : req0_addr;
            m_wdata = g1 ? req1_data : req0_data;
            m_we    = (m_waddr != 0);
            m_last  = g1;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        // Arbitration table, applied right after reset (requester 0 wins first tie).
        tbl[0] = '{1'b1, 1'b1, 5'd1,  5'd2,  1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 5'd3,  5'd4,  1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 5'd5,  5'd6,  1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 5'd7,  5'd8,  1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 5'd9,  5'd9,  1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 5'd9,  5'd10, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 5'd11, 5'd12, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 5'd13, 5'd2,  1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 5'd14, 5'd15, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 5'd3,  5'd0,  1'b0, 1'b1};

        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_pending_cnt", pending_cnt, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            logic [4:0]  ea;
            logic [31:0] ed;
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = 32'hA000_0000 | 32'(tbl[i].a0);
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = 32'hB000_0000 | 32'(tbl[i].a1);
            #1;
            chk("tbl_ready0", req0_ready, tbl[i].r0);
            chk("tbl_ready1", req1_ready, tbl[i].r1);
            @(posedge clk);
            #1;
            ea = tbl[i].r1 ? tbl[i].a1 : tbl[i].a0;
            ed = tbl[i].r1 ? (32'hB000_0000 | 32'(tbl[i].a1)) : (32'hA000_0000 | 32'(tbl[i].a0));
            chk("tbl_rf_we", rf_we, (tbl[i].r0 || tbl[i].r1) && (ea != 0));
            if (tbl[i].r0 || tbl[i].r1) begin
                chk("tbl_rf_waddr", rf_waddr, ea);
                chk("tbl_rf_wdata", rf_wdata, ed);
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("tbl_x0_sb_unchanged", pending_cnt, 0);
        @(negedge clk);

        // Claim x5, then write it back from requester 0.
        do_reset();
        rs1_addr = 5'd5;
        claim_valid = 1'b1; claim_addr = 5'd5;
        mcycle();
        claim_valid = 1'b0;
        #1;
        chk("seqA_busy_after_claim", rs1_busy, 1);
        chk("seqA_cnt_after_claim", pending_cnt, 1);
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        mcycle();
        req0_valid = 1'b0;
        #1;
        chk("seqA_rf_we", rf_we, 1);
        chk("seqA_rf_waddr", rf_waddr, 5);
        chk("seqA_rf_wdata", rf_wdata, 32'hDEADBEEF);
        mcycle();
        #1;
        chk("seqA_busy_cleared", rs1_busy, 0);
        chk("seqA_cnt_cleared", pending_cnt, 0);

        // WAW stall on x7, and claim of x9 on the edge its (unclaimed) write commits.
        claim_valid = 1'b1; claim_addr = 5'd7;
        mcycle();
        #1;
        chk("seqB_stall_second_claim", claim_stall, 1);
        mcycle();
        claim_valid = 1'b0;
        #1;
        chk("seqB_cnt_still_one", pending_cnt, 1);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0909;
        mcycle();
        req0_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd9; rs2_addr = 5'd9;
        #1;
        chk("seqB_commit_x9", rf_we, 1);
        mcycle();
        claim_valid = 1'b0;
        #1;
        chk("seqB_set_wins", rs2_busy, 1);
        chk("seqB_cnt_two", pending_cnt, 2);

        // Asynchronous reset while a write is on the port.
        do_reset();
        rs1_addr = 5'd3;
        claim_valid = 1'b1; claim_addr = 5'd3;
        mcycle();
        claim_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h55;
        mcycle();
        req1_valid = 1'b0;
        #1;
        chk("seqD_we_before_rst", rf_we, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("seqD_we_async", rf_we, 0);
        chk("seqD_cnt_async", pending_cnt, 0);
        chk("seqD_busy_async", rs1_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
        #1;
        chk("seqD_tie_ready0", req0_ready, 1);
        chk("seqD_tie_ready1", req1_ready, 0);
        mcycle();

        // Randomized traffic against the model, biased onto few registers for hazards.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            claim_valid = 1'($urandom_range(0, 1));
            claim_addr  = 5'($urandom_range(0, 7));
            req0_valid  = 1'($urandom_range(0, 1));
            req0_addr   = 5'($urandom_range(0, 7));
            req0_data   = $urandom;
            req1_valid  = 1'($urandom_range(0, 1));
            req1_addr   = 5'($urandom_range(0, 7));
            req1_data   = $urandom;
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 31));
            mcycle();
        end
        idle_inputs();
        mcycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
